regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter DW, default 32, data width in bits.
REQ-002 SHALL provide parameter AW, default 5, address width, giving 2^AW registers with register 0 hardwired to zero.
REQ-003 SHALL provide parameter NRP, default 2, number of read ports, legal range 1..4.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port clrn  in  1  reset; synchronous and active-high.
REQ-006 SHALL have port rn  in  NRP*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-007 SHALL have port q  out  NRP*DW  read data; port i occupies bits [i*DW +: DW].
REQ-008 SHALL have port rbusy  out  NRP  per-port flag: the addressed register has a pending write.
REQ-009 SHALL have port we  in  1  writeback enable.
REQ-010 SHALL have port wn  in  AW  writeback register number.
REQ-011 SHALL have port d  in  DW  writeback data.
REQ-012 SHALL have port iss_v  in  1  issue valid; marks iss_wn as pending.
REQ-013 SHALL have port iss_wn  in  AW  issued destination register number.
REQ-014 SHALL have port clr_req  in  1  request to scrub all registers to zero.
REQ-015 SHALL have port clr_busy  out  1  high while a scrub is in progress.
REQ-016 SHALL have port drop  out  1  one-cycle pulse: a write or issue was discarded.

Function
REQ-017 SHALL read combinationally: q[i] = 0 if rn[i]==0; otherwise = d when we && wn==rn[i] && state IDLE (write-through bypass); otherwise = stored register.
REQ-018 SHALL, in IDLE, on we && wn!=0, store d into register wn at the clock edge and clear pending[wn].
REQ-019 SHALL ignore we and iss_v when targeting register 0; no drop pulse in this case.
REQ-020 SHALL, in IDLE, on iss_v && iss_wn!=0, set pending[iss_wn] at the clock edge.
REQ-021 SHALL, when iss_v and we target the same nonzero register in one cycle, store d and leave pending set (issue wins).
REQ-022 SHALL drive rbusy[i] = pending[rn[i]] && !(we && wn==rn[i]) in IDLE; rbusy[i]=0 for rn[i]==0.
REQ-023 SHALL implement FSM states IDLE and SCRUB with a scrub pointer ptr of AW bits.
REQ-024 SHALL go IDLE->SCRUB on clr_req, loading ptr=1; a same-cycle we/iss_v SHALL be processed normally in that cycle.
REQ-025 SHALL in SCRUB, each cycle, zero register[ptr] and clear pending[ptr], then increment ptr.
REQ-026 SHALL go SCRUB->IDLE in the cycle ptr==2^AW-1 is scrubbed; scrub lasts exactly 2^AW-1 cycles (31 at default).
REQ-027 SHALL hold clr_busy=1 exactly while in SCRUB.
REQ-028 SHALL in SCRUB ignore clr_req, we and iss_v, and force every rbusy bit to 1; q returns current stored contents without bypass.
REQ-029 SHALL pulse drop for one cycle, the cycle after any we or iss_v with nonzero target arrives during SCRUB.

Reset
REQ-030 SHALL, while clrn=1 at a clock edge, zero all registers and all pending bits, enter IDLE, set ptr=0, clr_busy=0, drop=0.
REQ-031 SHALL give clrn priority over every other input, including mid-scrub, which is abandoned.
REQ-032 SHALL start with all registers zero at time zero without requiring a reset.

Verification
REQ-033 SHALL check: write 0xDEADBEEF to r5, read rn0=5 same cycle -> q0=0xDEADBEEF via bypass; next cycle without we -> q0=0xDEADBEEF from storage.
REQ-034 SHALL check: iss_v to r7, then read rn1=7 -> rbusy[1]=1; we to r7 with 0x12 -> rbusy[1]=0 same cycle, q1=0x12.
REQ-035 SHALL check: we to r0 with 0xFFFFFFFF -> q for rn=0 stays 0, drop stays 0.
REQ-036 SHALL check: fill r1..r31 nonzero, pulse clr_req -> clr_busy high 31 cycles, all rbusy=1, every register 0 afterwards; we during scrub -> drop pulses next cycle, value not stored.
REQ-037 SHALL check: clrn asserted on scrub cycle 10 -> next cycle clr_busy=0, all registers 0, pending cleared.
REQ-038 SHALL check: iss_v and we to r3 same cycle with 0x55 -> r3=0x55 and rbusy still 1 next cycle; repeat with NRP=4, DW=16, AW=4 -> scrub lasts 15 cycles.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: 2^AW x DW register file with register 0 hardwired to zero.
// It has NRP combinational read ports with a write-through bypass. A
// per-register pending (scoreboard) bit is set at issue and cleared at
// writeback. A scrub sequencer zeroes registers 1..2^AW-1, one per cycle.
module regfile_sb #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRP = 2
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [NRP*AW-1:0] rn,
    output logic [NRP*DW-1:0] q,
    output logic [NRP-1:0]    rbusy,
    input  logic              we,
    input  logic [AW-1:0]     wn,
    input  logic [DW-1:0]     d,
    input  logic              iss_v,
    input  logic [AW-1:0]     iss_wn,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              drop
);

    localparam int NREG = 1 << AW;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } state_t;

    // Power-up values make the file read as all-zero before any reset.
    state_t          state_q = IDLE;
    state_t          state_d;
    logic [AW-1:0]   ptr_q = '0;
    logic [NREG-1:0] pending_q = '0;
    logic [DW-1:0]   regs_q [NREG] = '{default: '0};
    logic            drop_q = 1'b0;

    logic in_scrub;
    logic wr_en;
    logic iss_en;
    logic lost;

    // State register; reset abandons any scrub in progress.
    always_ff @(posedge clk) begin
        if (clrn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a scrub request starts a sweep, which ends on the last register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req) state_d = SCRUB;
            SCRUB:   if (ptr_q == {AW{1'b1}}) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs of the FSM: qualified write/issue enables and the discard condition.
    always_comb begin
        in_scrub = (state_q == SCRUB);
        wr_en    = !in_scrub && we && (wn != '0);
        iss_en   = !in_scrub && iss_v && (iss_wn != '0);
        lost     = in_scrub && ((we && (wn != '0)) || (iss_v && (iss_wn != '0)));
    end

    assign clr_busy = in_scrub;
    assign drop     = drop_q;

    // Storage, scoreboard and scrub pointer; the issue update follows the
    // writeback update so that an issue in the same cycle leaves the bit set.
    always_ff @(posedge clk) begin
        if (clrn) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= '0;
            end
            pending_q <= '0;
            ptr_q     <= '0;
        end else if (in_scrub) begin
            regs_q[ptr_q]    <= '0;
            pending_q[ptr_q] <= 1'b0;
            ptr_q            <= ptr_q + AW'(1);
        end else begin
            if (wr_en) begin
                regs_q[wn]    <= d;
                pending_q[wn] <= 1'b0;
            end
            if (iss_en) begin
                pending_q[iss_wn] <= 1'b1;
            end
            if (clr_req) begin
                ptr_q <= AW'(1);
            end
        end
    end

    // One-cycle pulse after a write or issue that arrived while scrubbing.
    always_ff @(posedge clk) begin
        if (clrn) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= lost;
        end
    end

    // Read ports: register 0 reads zero; an idle writeback to the same
    // register is forwarded and masks that register's busy flag.
    genvar gi;
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_rd
            logic [AW-1:0] ra;
            logic          hit;
            assign ra  = rn[gi*AW +: AW];
            assign hit = !in_scrub && we && (wn == ra);
            assign q[gi*DW +: DW] = (ra == '0) ? '0 : (hit ? d : regs_q[ra]);
            assign rbusy[gi] = in_scrub || ((ra != '0) && pending_q[ra] && !hit);
        end
    endgenerate

endmodule
